// File: rtl/fft_pkg.sv
// Shared definitions for the FFT output-reorder slice.
//   FFT_LOG2N / FFT_N / FFT_DW : default transform size and component width
//   fft_sample_t               : packed complex sample {re, img}, both signed FFT_DW
//   rd_state_e                 : read-side FSM state encoding
//   bitrev()                   : FFT_LOG2N-bit index bit reversal
package fft_pkg;

    localparam int unsigned FFT_LOG2N = 8;
    localparam int unsigned FFT_N     = 256;
    localparam int unsigned FFT_DW    = 16;

    typedef struct packed {
        logic signed [FFT_DW-1:0] re;
        logic signed [FFT_DW-1:0] img;
    } fft_sample_t;

    typedef enum logic {
        StIdle,
        StRead
    } rd_state_e;

    function automatic logic [FFT_LOG2N-1:0] bitrev(input logic [FFT_LOG2N-1:0] idx);
        logic [FFT_LOG2N-1:0] r;
        for (int i = 0; i < int'(FFT_LOG2N); i++) begin
            r[i] = idx[int'(FFT_LOG2N)-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_bitrev_reorder_if.sv
// Sample stream bundle between the FFT core, the reorder stage and its consumer.
//   in_valid / in_xp_real / in_xp_img    : bit-reversed-order samples into the reorder stage
//   out_valid / out_yp_real / out_yp_img : natural-order samples out of the reorder stage
//   out_last                             : marks bin N-1 of each output frame
// Modports: master = producer/consumer side (testbench), slave = reorder stage.
interface fft_bitrev_reorder_if
    import fft_pkg::*;
#(
    parameter int unsigned DW = FFT_DW
) ();

    logic                 in_valid;
    logic signed [DW-1:0] in_xp_real;
    logic signed [DW-1:0] in_xp_img;
    logic                 out_valid;
    logic signed [DW-1:0] out_yp_real;
    logic signed [DW-1:0] out_yp_img;
    logic                 out_last;

    modport master (
        output in_valid, in_xp_real, in_xp_img,
        input  out_valid, out_yp_real, out_yp_img, out_last
    );

    modport slave (
        input  in_valid, in_xp_real, in_xp_img,
        output out_valid, out_yp_real, out_yp_img, out_last
    );

endinterface

// File: rtl/fft_pingpong_ram.sv
// Two-bank sample buffer for the reorder stage.
//   clk                              : write and read clock
//   we / wr_bank / wr_addr / wr_data : write port
//   re / rd_bank / rd_addr           : synchronous read request
//   rd_data                          : read data, registered; holds when re=0
// Arrays carry no reset; contents are meaningless until written.
module fft_pingpong_ram
    import fft_pkg::*;
#(
    parameter int unsigned LOG2N = FFT_LOG2N,
    parameter int unsigned DW    = FFT_DW
) (
    input  logic              clk,
    input  logic              we,
    input  logic              wr_bank,
    input  logic [LOG2N-1:0]  wr_addr,
    input  logic [2*DW-1:0]   wr_data,
    input  logic              re,
    input  logic              rd_bank,
    input  logic [LOG2N-1:0]  rd_addr,
    output logic [2*DW-1:0]   rd_data
);

    localparam int unsigned N = 2**LOG2N;

    logic [2*DW-1:0] mem [2][N];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_bank][wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (re) begin
            rd_data <= mem[rd_bank][rd_addr];
        end
    end

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Bit-reversed to natural-order reorder stage behind a radix-2 FFT core.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of the sample stream (bit-reversed in, natural order out)
// Each input frame is written into one bank at bitrev(wr_cnt); once the bank is
// full it is read out linearly while the next frame fills the other bank.
module fft_bitrev_reorder
    import fft_pkg::*;
#(
    parameter int unsigned LOG2N = FFT_LOG2N,
    parameter int unsigned DW    = FFT_DW
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fft_bitrev_reorder_if.slave  bus
);

    localparam int unsigned      N       = 2**LOG2N;
    localparam logic [LOG2N-1:0] CNT_MAX = LOG2N'(N - 1);

    logic [LOG2N-1:0] wr_cnt_q, wr_cnt_d, wr_addr;
    logic             wr_bank_q, wr_bank_d;
    logic             wr_done;
    logic [1:0]       full_q, full_d;
    logic [LOG2N-1:0] rd_cnt_q, rd_cnt_d;
    logic             rd_bank_q, rd_bank_d;
    logic             rd_en, rd_done;
    rd_state_e        state_q, state_d;
    logic             out_valid_q, out_last_q;
    logic [2*DW-1:0]  rd_data;

    // Write side

    always_comb begin
        wr_addr = '0;
        for (int i = 0; i < int'(LOG2N); i++) begin
            wr_addr[i] = wr_cnt_q[int'(LOG2N)-1-i];
        end
    end

    assign wr_done = bus.in_valid && (wr_cnt_q == CNT_MAX);

    always_comb begin
        wr_cnt_d  = wr_cnt_q;
        wr_bank_d = wr_bank_q;
        if (bus.in_valid) begin
            wr_cnt_d = wr_cnt_q + 1'b1;  // wraps to 0 after N-1
            if (wr_done) begin
                wr_bank_d = ~wr_bank_q;
            end
        end
    end

    // Set and clear can land on the same edge but always on different banks.
    always_comb begin
        full_d = full_q;
        if (wr_done) begin
            full_d[wr_bank_q] = 1'b1;
        end
        if (rd_done) begin
            full_d[rd_bank_q] = 1'b0;
        end
    end

    // Read FSM: state register / next state / outputs

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (full_q[rd_bank_q]) begin
                    state_d = StRead;
                end
            end
            StRead: begin
                // Look at full_d so a frame completing on this very edge keeps
                // the output stream gap-free.
                if (rd_cnt_q == CNT_MAX) begin
                    state_d = full_d[rd_bank_d] ? StRead : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // The first read is issued on the IDLE->READ edge itself.
    always_comb begin
        rd_en = 1'b0;
        unique case (state_q)
            StIdle:  rd_en = full_q[rd_bank_q];
            StRead:  rd_en = 1'b1;
            default: rd_en = 1'b0;
        endcase
        rd_done = rd_en && (rd_cnt_q == CNT_MAX);
    end

    always_comb begin
        rd_cnt_d  = rd_en ? rd_cnt_q + 1'b1 : rd_cnt_q;
        rd_bank_d = rd_done ? ~rd_bank_q : rd_bank_q;
    end

    // State registers

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt_q    <= '0;
            wr_bank_q   <= 1'b0;
            full_q      <= '0;
            rd_cnt_q    <= '0;
            rd_bank_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            wr_cnt_q    <= wr_cnt_d;
            wr_bank_q   <= wr_bank_d;
            full_q      <= full_d;
            rd_cnt_q    <= rd_cnt_d;
            rd_bank_q   <= rd_bank_d;
            out_valid_q <= rd_en;
            out_last_q  <= rd_done;
        end
    end

    fft_pingpong_ram #(
        .LOG2N (LOG2N),
        .DW    (DW)
    ) u_ram (
        .clk     (clk),
        .we      (bus.in_valid),
        .wr_bank (wr_bank_q),
        .wr_addr (wr_addr),
        .wr_data ({bus.in_xp_real, bus.in_xp_img}),
        .re      (rd_en),
        .rd_bank (rd_bank_q),
        .rd_addr (rd_cnt_q),
        .rd_data (rd_data)
    );

    // The RAM read register doubles as the output data register; it is only
    // exposed while out_valid is high so idle cycles present zeros.
    assign bus.out_valid   = out_valid_q;
    assign bus.out_last    = out_last_q;
    assign bus.out_yp_real = out_valid_q ? rd_data[2*DW-1:DW] : '0;
    assign bus.out_yp_img  = out_valid_q ? rd_data[DW-1:0]    : '0;

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
module tb_fft_bitrev_reorder;
    import fft_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    fft_bitrev_reorder_if #(.DW(FFT_DW)) bus ();

    fft_bitrev_reorder #(
        .LOG2N (FFT_LOG2N),
        .DW    (FFT_DW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        fft_sample_t data;
        logic        last;
        int          cyc;
    } exp_t;

    typedef struct {
        int          in_idx;
        fft_sample_t val;
        int          exp_bin;
    } spike_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    exp_t        sb[$];
    fft_sample_t in_frame[FFT_N];
    fft_sample_t exp_frame[FFT_N];
    spike_t      tbl[5];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Output monitor / scoreboard consumer
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_out_valid", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("out_data", {bus.out_yp_real, bus.out_yp_img}, e.data);
                    check("out_last", bus.out_last, e.last);
                    check("out_timing", cyc, e.cyc);
                end
            end else begin
                check("idle_zero", {bus.out_valid, bus.out_last, bus.out_yp_real,
                                    bus.out_yp_img}, 64'd0);
                if (sb.size() > 0 && sb[0].cyc <= cyc) begin
                    e = sb.pop_front();
                    check("missing_output", 64'd0, 64'd1);
                end
            end
        end
    end

    task automatic push_expected(input int e_edge);
        for (int k = 0; k < int'(FFT_N); k++) begin
            sb.push_back('{data: exp_frame[k], last: (k == int'(FFT_N) - 1),
                           cyc: e_edge + 1 + k});
        end
    endtask

    // Drives n samples from in_frame; pauses glen cycles after samples g0/g1/g2.
    task automatic send_frame(input int n, input int g0, input int g1, input int g2,
                              input int glen);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.in_valid   = 1'b1;
            bus.in_xp_real = in_frame[i].re;
            bus.in_xp_img  = in_frame[i].img;
            if (i == int'(FFT_N) - 1) push_expected(cyc + 1);
            if (i == g0 || i == g1 || i == g2) begin
                for (int j = 0; j < glen; j++) begin
                    @(negedge clk);
                    bus.in_valid = 1'b0;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.in_valid   = 1'b0;
            bus.in_xp_real = '0;
            bus.in_xp_img  = '0;
        end
    endtask

    task automatic wait_drain();
        int t = 0;
        while (sb.size() > 0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() > 0) begin
            check("drain_timeout", sb.size(), 64'd0);
            sb.delete();
        end
        idle(3);
    endtask

    function automatic void ramp(input int f);
        int v;
        for (int i = 0; i < int'(FFT_N); i++) begin
            v = f * 256 + int'(bitrev(8'(i)));
            in_frame[i].re  = 16'(v);
            in_frame[i].img = 16'(-v);
            v = f * 256 + i;
            exp_frame[i].re  = 16'(v);
            exp_frame[i].img = 16'(-v);
        end
    endfunction

    initial begin
        tbl[0] = '{in_idx: 1,   val: '{re: 16'sh8000, img: 16'sh7fff}, exp_bin: 128};
        tbl[1] = '{in_idx: 0,   val: '{re: 16'sh0001, img: 16'shffff}, exp_bin: 0};
        tbl[2] = '{in_idx: 255, val: '{re: 16'shffff, img: 16'sh8000}, exp_bin: 255};
        tbl[3] = '{in_idx: 128, val: '{re: 16'sh1234, img: 16'shedcc}, exp_bin: 1};
        tbl[4] = '{in_idx: 3,   val: '{re: 16'sh0005, img: 16'sh0007}, exp_bin: 192};

        bus.in_valid   = 1'b0;
        bus.in_xp_real = '0;
        bus.in_xp_img  = '0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(4);

        // Single ramp frame
        ramp(0);
        send_frame(256, -1, -1, -1, 0);
        idle(1);
        wait_drain();

        // Three back-to-back frames; timestamps demand a continuous 768-cycle burst
        for (int f = 0; f < 3; f++) begin
            ramp(f);
            send_frame(256, -1, -1, -1, 0);
        end
        idle(1);
        wait_drain();

        // Gapped input
        ramp(0);
        send_frame(256, 0, 100, 254, 5);
        idle(1);
        wait_drain();

        // Single-spike frames, including the full-scale extremes
        for (int t = 0; t < 5; t++) begin
            for (int i = 0; i < int'(FFT_N); i++) begin
                in_frame[i]  = '0;
                exp_frame[i] = '0;
            end
            in_frame[tbl[t].in_idx]   = tbl[t].val;
            exp_frame[tbl[t].exp_bin] = tbl[t].val;
            send_frame(256, -1, -1, -1, 0);
            idle(1);
            wait_drain();
        end

        // Reset in the middle of an input frame
        ramp(7);
        send_frame(130, -1, -1, -1, 0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        ramp(1);
        send_frame(256, -1, -1, -1, 0);
        idle(1);
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fft_bitrev_reorder.md
Name: fft_bitrev_reorder

Overview:
- Output reorder stage placed directly downstream of the 256-point radix-2 FFT core.
- The core emits each frame's 256 bins in bit-reversed index order. This block buffers each frame and re-emits it in natural order (bin 0..255), with out_valid held high for 256 consecutive cycles per frame.
- Uses a ping-pong double buffer, so back-to-back frames stream with no gaps.

Parameters:
- LOG2N, 8, log2 of FFT size; N = 2**LOG2N samples per frame
- DW, 16, width of each real/imag component (signed Q1.15)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  one input sample present this cycle
- in_xp_real  in  DW  signed real part of input sample, bit-reversed order
- in_xp_img  in  DW  signed imag part of input sample, bit-reversed order
- out_valid  out  1  output sample valid
- out_yp_real  out  DW  signed real part, natural order
- out_yp_img  out  DW  signed imag part, natural order
- out_last  out  1  high with the 256th sample (bin 255) of each frame

Behaviour:
- Reset: asynchronous active-low, one clock. While rst_n=0, all outputs are 0. All counters, bank flags and bank pointers are cleared; buffer contents are don't-care.
- Storage: two banks, each N x 2*DW. wr_bank and rd_bank pointers reset to 0.
- Write side:
  - 8-bit wr_cnt counts accepted samples within a frame.
  - On each edge with in_valid=1, the sample is written to bank wr_bank at address bitrev(wr_cnt), then wr_cnt increments.
  - When wr_cnt==N-1 is accepted: set full[wr_bank], toggle wr_bank, and wr_cnt wraps to 0.
- Input gaps: in_valid may drop mid-frame. wr_cnt holds its value and there is no timeout.
- Read FSM states: IDLE, READ.
  - IDLE -> READ on the edge where full[rd_bank] is observed set (i.e., the edge after the last write).
  - In READ, each edge registers mem[rd_bank][rd_cnt] onto the outputs, sets out_valid=1, and increments rd_cnt.
  - On the edge reading address N-1: out_last=1, clear full[rd_bank], toggle rd_bank, rd_cnt wraps to 0.
  - After that edge: if full[new rd_bank] is set, stay in READ, so out_valid stays continuous across frames. Otherwise go to IDLE.
- Outputs are registered. When out_valid=0, out_yp_real, out_yp_img and out_last are driven to 0.
- Latency: if the 256th input sample is sampled at edge E, out_valid=1 with bin 0 from edge E+1. Bin k is presented after edge E+1+k.
- Throughput: continuous in_valid at 1 sample/cycle is sustained indefinitely. A frame's last write and the previous frame's last read may land on the same edge; full set and clear then target different banks, and both take effect.
- Simultaneous same-bank set/clear cannot occur under 1 sample/cycle input; no arbitration is required.
- Arithmetic: pure data movement, no rounding or saturation; bits pass through unchanged.
- Reset mid-frame: a partial input frame and any in-progress output are discarded. After release, the next in_valid starts a new frame at wr_cnt=0.

Decomposition:
- Shared package fft_pkg:
  - constants FFT_LOG2N=8, FFT_N=256, FFT_DW=16
  - typedef of a complex sample struct {real, img} each signed FFT_DW
  - function bitrev(idx) for LOG2N bits
- Sub-module fft_pingpong_ram:
  - two banks of N x 2*DW
  - one write port (bank, addr, data, we)
  - one synchronous read port (bank, addr); no reset on the arrays

Test Plan:
- Reset check: hold rst_n=0 for 2 cycles, release -> out_valid=0, out_yp_real=0, out_yp_img=0, out_last=0 while in_valid stays 0.
- Ramp frame:
  - Stimulus: drive 256 samples, sample i = (real=bitrev(i), img=-bitrev(i)).
  - Response: out_valid rises 1 cycle after the last input; output k = (k, -k) for k=0..255. out_last is high only at k=255, then out_valid drops.
- Back-to-back frames:
  - Stimulus: 3 frames, 768 consecutive in_valid cycles; frame f sample value = f*256+bitrev(i).
  - Response: out_valid high for exactly 768 consecutive cycles, values f*256+k in order, and out_last at every 256th output.
- Gapped input: same ramp frame with in_valid=0 for 5 cycles after samples 0, 100 and 254 -> identical natural-order output with the same E+1 latency.
- Extremes: real=-32768, img=32767 at bit-reversed address 1 (bin 128), all other samples 0 -> bin 128 = (-32768, 32767) bit-exact, all other bins 0.
- Mid-frame reset: reset asserted after 130 input samples; then a full ramp frame -> only the post-reset frame is output, correct and complete, 256 cycles.
